// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch unit: queue entry layout and the fetch mode enum.
// FETCH_MISALIGN_EN adds the misaligned flag to fetch_entry_t.
package fetch_unit_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_XLEN  = 32;
  localparam int FETCH_ILEN  = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] instr;
`ifdef FETCH_MISALIGN_EN
    logic                  misaligned;
`endif
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_RUN,
    FS_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry queue of fetch_entry_t kept as a shift register so the head is
// always entry 0; flush takes priority over pop and may be combined with push.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  fetch_entry_t                 i_push_data,
  input  logic                         i_pop,
  output fetch_entry_t                 o_head,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [CW-1:0]  r_count;
  logic           w_pop;
  logic [AW-1:0]  w_wr_idx;

  assign w_pop    = i_pop && (r_count != '0);
  assign w_wr_idx = w_pop ? AW'(r_count - CW'(1)) : AW'(r_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_count <= i_push ? CW'(1) : '0;
      if (i_push) r_mem[0] <= i_push_data;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      // a push lands after the shift, so push+pop on a full queue keeps count
      if (i_push) r_mem[w_wr_idx] <= i_push_data;
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  assign o_head  = r_mem[0];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

`ifdef FORMAL
  always_ff @(posedge clk) begin
    if (!rst && i_push && !i_flush && !w_pop) assert (r_count != CW'(DEPTH));
  end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a credit-limited request stream, an output
// queue and redirect flush. FETCH_MISALIGN_EN adds out_misaligned reporting.
//
// state   | meaning
// FS_IDLE | first cycle out of reset, no request issued
// FS_RUN  | sequential fetch
// FS_HOLD | misaligned redirect entry queued; requests suppressed until redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter int              ILEN     = FETCH_ILEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
`ifdef FETCH_MISALIGN_EN
  ,
  output logic            out_misaligned
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t    r_state, w_state_next;
  logic [XLEN-1:0] r_fetch_pc, r_resp_pc, w_redir_pc;
  logic [CW-1:0]   r_inflight, r_drop, w_inflight_next, w_count;
  logic [CW:0]     w_credit;
  logic            w_misaligned, w_req_fire, w_drop_hit, w_resp_push, w_push, w_empty;
  fetch_entry_t    w_push_data, w_head;

`ifdef FETCH_MISALIGN_EN
  assign w_redir_pc     = redirect_pc;
  assign w_misaligned   = |redirect_pc[1:0];
  assign out_misaligned = w_head.misaligned;
`else
  assign w_redir_pc     = redirect_pc & ~XLEN'(3);
  assign w_misaligned   = 1'b0;
`endif

  // drop <= inflight always holds, so the credit sum never underflows
  assign w_credit = {1'b0, w_count} + {1'b0, r_inflight} - {1'b0, r_drop};

  always_comb begin
    w_state_next   = r_state;
    imem_req_valid = 1'b0;
    if (redirect_valid) w_state_next = w_misaligned ? FS_HOLD : FS_RUN;
    else if (r_state == FS_IDLE) w_state_next = FS_RUN;
    if (r_state == FS_RUN && !redirect_valid && w_credit < (CW+1)'(DEPTH))
      imem_req_valid = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FS_IDLE;
    else       r_state <= w_state_next;
  end

  assign imem_addr       = r_fetch_pc;
  assign w_req_fire      = imem_req_valid && imem_req_ready;
  assign w_inflight_next = r_inflight + CW'(w_req_fire) - CW'(imem_resp_valid);
  assign w_drop_hit      = imem_resp_valid && (r_drop != '0);
  assign w_resp_push     = imem_resp_valid && !w_drop_hit && !redirect_valid;
  assign w_push          = redirect_valid ? w_misaligned : w_resp_push;

  always_comb begin
    w_push_data = '0;
    if (redirect_valid) begin
      w_push_data.pc = w_redir_pc;
`ifdef FETCH_MISALIGN_EN
      w_push_data.misaligned = 1'b1;
`endif
    end else begin
      w_push_data.pc    = r_resp_pc;
      w_push_data.instr = imem_resp_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= w_inflight_next;
      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        r_drop     <= w_inflight_next;
      end else begin
        if (w_req_fire)  r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
        if (w_resp_push) r_resp_pc  <= r_resp_pc + XLEN'(INSTR_BYTES);
        if (w_drop_hit)  r_drop     <= r_drop - CW'(1);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (out_ready),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign out_valid = !w_empty;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order imem model with variable latency and a
// request-level reference model; directed sequences, a redirect table, random run.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_MISALIGN_EN
  logic        out_misaligned;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
`ifdef FETCH_MISALIGN_EN
    ,
    .out_misaligned  (out_misaligned)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          mis;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    int          lat;
    logic [31:0] pc;
    logic [31:0] exp_pc;
    int          exp_lat;
  } vec_t;

  exp_t        q[$];
  pend_t       pend[$];
  logic [31:0] m_fetch_pc;
  bit          m_active, m_hold;
  int          cyc, last_due;
  int          g_lat_min = 1, g_lat_max = 1;
  bit          g_rdy_rand = 0, g_hold_mem = 0, g_fire;
  int          n_pass = 0, n_total = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] mask_pc(logic [31:0] p);
`ifdef FETCH_MISALIGN_EN
    return p;
`else
    return p & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic bit is_mis(logic [31:0] p);
`ifdef FETCH_MISALIGN_EN
    return (p & 32'h3) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: drive imem response, compare against model, advance model.
  task automatic tick();
    bit    resp_now, exp_req, pop;
    int    live, lat, due;
    pend_t h;
    resp_now        = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? mem_word(pend[0].addr) : $urandom();
    imem_req_ready  = !g_hold_mem && (pend.size() < 4) &&
                      (!g_rdy_rand || ($urandom_range(0, 3) != 0));
    #4;
    live = 0;
    foreach (pend[i]) if (!pend[i].stale) live++;
    exp_req = m_active && !m_hold && !redirect_valid && (q.size() + live) < DEPTH;
    chk("req_valid", imem_req_valid, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
`ifdef FETCH_MISALIGN_EN
      chk("out_misaligned", out_misaligned, q[0].mis);
`endif
    end
    g_fire = imem_req_valid && imem_req_ready;
    pop    = out_valid && out_ready;
    if (resp_now) h = pend.pop_front();
    if (redirect_valid) begin
      q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_fetch_pc = mask_pc(redirect_pc);
      m_hold     = is_mis(redirect_pc);
      if (m_hold) q.push_back('{pc: redirect_pc, instr: 32'h0, mis: 1'b1});
    end else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (resp_now && !h.stale) q.push_back('{pc: h.addr, instr: mem_word(h.addr), mis: 1'b0});
      if (g_fire) m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (g_fire) begin
      lat = $urandom_range(g_lat_min, g_lat_max);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: imem_addr, due: due, stale: redirect_valid});
    end
    m_active = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    q.delete();
    pend.delete();
    m_fetch_pc = 32'h0;
    m_active   = 1'b0;
    m_hold     = 1'b0;
    cyc        = 0;
    last_due   = -1;
    reset      = 1'b0;
  endtask

  task automatic wait_valid(string name, logic [31:0] exp_pc);
    int k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_pc"}, out_pc, exp_pc);
  endtask

  task automatic drain_mem();
    int k = 0;
    g_hold_mem = 1'b1;
    while (pend.size() > 0 && k < 40) begin
      tick();
      k++;
    end
    g_hold_mem = 1'b0;
  endtask

  vec_t tbl[5];
  int   first, nreq, k;
  bit   found;

  initial begin
    tbl[0] = '{lat: 1, pc: 32'h0000_0100, exp_pc: 32'h0000_0100, exp_lat: 3};
    tbl[1] = '{lat: 3, pc: 32'h0000_0200, exp_pc: 32'h0000_0200, exp_lat: 5};
    tbl[2] = '{lat: 4, pc: 32'hFFFF_FFF8, exp_pc: 32'hFFFF_FFF8, exp_lat: 6};
`ifdef FETCH_MISALIGN_EN
    tbl[3] = '{lat: 1, pc: 32'h0000_0303, exp_pc: 32'h0000_0303, exp_lat: 1};
`else
    tbl[3] = '{lat: 1, pc: 32'h0000_0303, exp_pc: 32'h0000_0300, exp_lat: 3};
`endif
    tbl[4] = '{lat: 2, pc: 32'h0000_1000, exp_pc: 32'h0000_1000, exp_lat: 4};

    // 1-cycle memory, decode always ready
    out_ready = 1'b1;
    do_reset();
    first = -1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid && first < 0) first = cyc;
      if (cyc >= 3 && cyc <= 5) chk("seq_out_pc", out_pc, 32'((cyc - 3) * 4));
      tick();
    end
    chk("first_out_valid_cycle", first, 3);

    // decode stalled: credits run out after DEPTH requests
    do_reset();
    out_ready = 1'b0;
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      nreq += int'(g_fire);
    end
    chk("stall_requests", nreq, DEPTH);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'(i * 4));
      tick();
    end

    // 3-cycle memory, redirect with two requests outstanding
    do_reset();
    g_lat_min = 3; g_lat_max = 3;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    wait_valid("redir_lat3", 32'h100);
    repeat (6) tick();

    // redirect coinciding with a pop and an arriving response
    g_lat_min = 2; g_lat_max = 2;
    found = 1'b0; k = 0;
    while (!found && k < 20) begin
      if (out_valid && pend.size() > 0 && pend[0].due <= cyc) found = 1'b1;
      else tick();
      k++;
    end
    chk("coincident_setup", out_valid && found, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    chk("coincident_flush", out_valid, 0);
    wait_valid("coincident_resume", 32'h400);

    // PC wrap
    g_lat_min = 1; g_lat_max = 1;
    drain_mem();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr_lo", imem_addr, 32'h0);
    repeat (4) tick();

`ifdef FETCH_MISALIGN_EN
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    chk("mis_valid", out_valid, 1);
    chk("mis_pc", out_pc, 32'h102);
    chk("mis_flag", out_misaligned, 1);
    chk("mis_instr", out_instr, 0);
    for (int i = 0; i < 5; i++) begin
      chk("mis_no_req", imem_req_valid, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    wait_valid("mis_resume", 32'h200);
    chk("mis_resume_flag", out_misaligned, 0);
`endif

    // redirect latency table
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      g_lat_min = tbl[v].lat; g_lat_max = tbl[v].lat;
      drain_mem();
      redirect_valid = 1'b1; redirect_pc = tbl[v].pc;
      tick();
      redirect_valid = 1'b0;
      k = 1;
      while (!out_valid && k < 30) begin
        tick();
        k++;
      end
      chk("tbl_latency", k, tbl[v].exp_lat);
      chk("tbl_pc", out_pc, tbl[v].exp_pc);
      repeat (3) tick();
    end

    // random traffic with one reset mid-stream
    g_rdy_rand = 1'b1; g_lat_min = 1; g_lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom();
`ifdef FETCH_MISALIGN_EN
      if ($urandom_range(0, 3) != 0) redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
      tick();
    end
    redirect_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
